// File: rtl/dcache_array.sv
// N-way set-associative L1 data-cache storage: tag/data/valid/dirty arrays,
// true-LRU per set, byte-masked store, victim-selecting fill and a one-entry writeback buffer.
module dcache_array #(
  parameter int WAYS   = 4,
  parameter int SETS   = 32,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 64,
  localparam int IDX_W = $clog2(SETS),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  ld_tag_i,
  input  logic [IDX_W-1:0]  ld_idx_i,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o,
  input  logic              st_en_i,
  input  logic [TAG_W-1:0]  st_tag_i,
  input  logic [IDX_W-1:0]  st_idx_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [BE_W-1:0]   st_be_i,
  output logic              st_hit_o,
  input  logic              fill_en_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [IDX_W-1:0]  fill_idx_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              fill_dirty_i,
  output logic              fill_rdy_o,
  output logic              wb_valid_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [IDX_W-1:0]  wb_idx_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic              wb_ready_i,
  input  logic [TAG_W-1:0]  snp_tag_i,
  input  logic [IDX_W-1:0]  snp_idx_i,
  input  logic              snp_inv_i,
  input  logic              snp_dgr_i,
  output logic              snp_hit_o,
  output logic              snp_dirty_o,
  output logic [DATA_W-1:0] snp_data_o,
  output logic              snp_wb_hit_o
);

  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  typedef logic [WAYS-1:0][AGE_W-1:0] ageSet_t;

  logic [TAG_W-1:0]  r_tag  [WAYS][SETS];
  logic [DATA_W-1:0] r_data [WAYS][SETS];
  logic [WAYS-1:0]   r_vld  [SETS];
  logic [WAYS-1:0]   r_dty  [SETS];
  ageSet_t           r_age  [SETS];

  logic              r_wbValid;
  logic [TAG_W-1:0]  r_wbTag;
  logic [IDX_W-1:0]  r_wbIdx;
  logic [DATA_W-1:0] r_wbData;

  logic [WAYS-1:0]  w_ldHitVec, w_stHitVec, w_snpHitVec, w_fillMatchVec, w_lruVec;
  logic [AGE_W-1:0] w_ldWay, w_stWay, w_snpWay, w_fillWay;
  logic             w_ldHit, w_stHit, w_snpHit, w_fillAccept, w_victim;
  ageSet_t          w_ageNext [SETS];

  // Lowest-index set bit; ties between ways always resolve to the lower way.
  function automatic logic [AGE_W-1:0] firstSet(input logic [WAYS-1:0] v);
    firstSet = '0;
    for (int j = WAYS - 1; j >= 0; j--) begin
      if (v[j]) firstSet = AGE_W'(j);
    end
  endfunction

  // Make way w MRU; every way younger than its old age ages by one.
  function automatic ageSet_t touch(input ageSet_t a, input logic [AGE_W-1:0] w);
    logic [AGE_W-1:0] old;
    touch = a;
    old   = a[w];
    for (int j = 0; j < WAYS; j++) begin
      if (a[j] < old) touch[j] = a[j] + AGE_W'(1);
    end
    touch[w] = '0;
  endfunction

  always_comb begin
    w_ldHitVec     = '0;
    w_stHitVec     = '0;
    w_snpHitVec    = '0;
    w_fillMatchVec = '0;
    w_lruVec       = '0;
    ld_data_o      = '0;
    snp_data_o     = '0;
    for (int j = 0; j < WAYS; j++) begin
      w_ldHitVec[j]     = r_vld[ld_idx_i][j]   && (r_tag[j][ld_idx_i]   == ld_tag_i);
      w_stHitVec[j]     = r_vld[st_idx_i][j]   && (r_tag[j][st_idx_i]   == st_tag_i);
      w_snpHitVec[j]    = r_vld[snp_idx_i][j]  && (r_tag[j][snp_idx_i]  == snp_tag_i);
      w_fillMatchVec[j] = r_vld[fill_idx_i][j] && (r_tag[j][fill_idx_i] == fill_tag_i);
      w_lruVec[j]       = (r_age[fill_idx_i][j] == AGE_W'(WAYS - 1));
      if (w_ldHitVec[j])  ld_data_o  = ld_data_o  | r_data[j][ld_idx_i];
      if (w_snpHitVec[j]) snp_data_o = snp_data_o | r_data[j][snp_idx_i];
    end
  end

  assign w_ldHit  = |w_ldHitVec;
  assign w_stHit  = |w_stHitVec;
  assign w_snpHit = |w_snpHitVec;
  assign w_ldWay  = firstSet(w_ldHitVec);
  assign w_stWay  = firstSet(w_stHitVec);
  assign w_snpWay = firstSet(w_snpHitVec);

  // Fill target priority: matching tag, then lowest invalid way, then LRU.
  assign w_fillWay = (|w_fillMatchVec)       ? firstSet(w_fillMatchVec) :
                     (~&r_vld[fill_idx_i])   ? firstSet(~r_vld[fill_idx_i]) :
                                               firstSet(w_lruVec);

  assign fill_rdy_o   = ~r_wbValid | wb_ready_i;
  assign w_fillAccept = fill_en_i & fill_rdy_o;
  assign w_victim     = w_fillAccept && r_vld[fill_idx_i][w_fillWay] &&
                        r_dty[fill_idx_i][w_fillWay] &&
                        (r_tag[w_fillWay][fill_idx_i] != fill_tag_i);

  assign ld_hit_o     = w_ldHit;
  assign st_hit_o     = w_stHit;
  assign snp_hit_o    = w_snpHit;
  assign snp_dirty_o  = |(w_snpHitVec & r_dty[snp_idx_i]);
  assign snp_wb_hit_o = r_wbValid && (r_wbTag == snp_tag_i) && (r_wbIdx == snp_idx_i);

  assign wb_valid_o = r_wbValid;
  assign wb_tag_o   = r_wbTag;
  assign wb_idx_o   = r_wbIdx;
  assign wb_data_o  = r_wbData;

  // Touches compose in priority order so a later touch sees the earlier one's ages.
  always_comb begin
    w_ageNext = r_age;
    if (w_ldHit)
      w_ageNext[ld_idx_i] = touch(w_ageNext[ld_idx_i], w_ldWay);
    if (st_en_i && w_stHit)
      w_ageNext[st_idx_i] = touch(w_ageNext[st_idx_i], w_stWay);
    if (w_fillAccept)
      w_ageNext[fill_idx_i] = touch(w_ageNext[fill_idx_i], w_fillWay);
  end

  // Later assignments win, giving store < snoop < fill on a shared way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_vld[s] <= '0;
        r_dty[s] <= '0;
        for (int j = 0; j < WAYS; j++) begin
          r_tag[j][s]  <= '0;
          r_data[j][s] <= '0;
          r_age[s][j]  <= AGE_W'(j);
        end
      end
      r_wbValid <= 1'b0;
      r_wbTag   <= '0;
      r_wbIdx   <= '0;
      r_wbData  <= '0;
    end else begin
      r_age <= w_ageNext;
      if (st_en_i && w_stHit) begin
        for (int b = 0; b < BE_W; b++) begin
          if (st_be_i[b]) r_data[w_stWay][st_idx_i][8*b +: 8] <= st_data_i[8*b +: 8];
        end
        r_dty[st_idx_i][w_stWay] <= 1'b1;
      end
      if (w_snpHit) begin
        if (snp_inv_i || snp_dgr_i) r_dty[snp_idx_i][w_snpWay] <= 1'b0;
        if (snp_inv_i)              r_vld[snp_idx_i][w_snpWay] <= 1'b0;
      end
      if (w_fillAccept) begin
        r_tag[w_fillWay][fill_idx_i]  <= fill_tag_i;
        r_data[w_fillWay][fill_idx_i] <= fill_data_i;
        r_vld[fill_idx_i][w_fillWay]  <= 1'b1;
        r_dty[fill_idx_i][w_fillWay]  <= fill_dirty_i;
      end
      if (w_victim) begin
        r_wbValid <= 1'b1;
        r_wbTag   <= r_tag[w_fillWay][fill_idx_i];
        r_wbIdx   <= fill_idx_i;
        r_wbData  <= r_data[w_fillWay][fill_idx_i];
      end else if (r_wbValid && wb_ready_i) begin
        r_wbValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_array.sv
// Directed, table-driven bench for dcache_array (WAYS=4, SETS=32, TAG_W=8, DATA_W=64).
module tb_dcache_array;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ld_tag_i, st_tag_i, fill_tag_i, snp_tag_i;
  logic [4:0]  ld_idx_i, st_idx_i, fill_idx_i, snp_idx_i;
  logic [63:0] st_data_i, fill_data_i;
  logic [7:0]  st_be_i;
  logic        st_en_i, fill_en_i, fill_dirty_i, wb_ready_i, snp_inv_i, snp_dgr_i;
  logic        ld_hit_o, st_hit_o, fill_rdy_o, wb_valid_o, snp_hit_o, snp_dirty_o, snp_wb_hit_o;
  logic [63:0] ld_data_o, wb_data_o, snp_data_o;
  logic [7:0]  wb_tag_o;
  logic [4:0]  wb_idx_o;

  always #5 clk = ~clk;

  dcache_array #(.WAYS(4), .SETS(32), .TAG_W(8), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ld_tag_i(ld_tag_i), .ld_idx_i(ld_idx_i), .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o),
    .st_en_i(st_en_i), .st_tag_i(st_tag_i), .st_idx_i(st_idx_i), .st_data_i(st_data_i),
    .st_be_i(st_be_i), .st_hit_o(st_hit_o),
    .fill_en_i(fill_en_i), .fill_tag_i(fill_tag_i), .fill_idx_i(fill_idx_i),
    .fill_data_i(fill_data_i), .fill_dirty_i(fill_dirty_i), .fill_rdy_o(fill_rdy_o),
    .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o), .wb_idx_o(wb_idx_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready_i),
    .snp_tag_i(snp_tag_i), .snp_idx_i(snp_idx_i), .snp_inv_i(snp_inv_i), .snp_dgr_i(snp_dgr_i),
    .snp_hit_o(snp_hit_o), .snp_dirty_o(snp_dirty_o), .snp_data_o(snp_data_o),
    .snp_wb_hit_o(snp_wb_hit_o)
  );

  typedef struct packed {
    logic [7:0] ldTag;  logic [4:0] ldIdx;
    logic stEn; logic [7:0] stTag; logic [4:0] stIdx; logic [63:0] stData; logic [7:0] stBe;
    logic fillEn; logic [7:0] fillTag; logic [4:0] fillIdx; logic [63:0] fillData; logic fillDirty;
    logic wbReady;
    logic [7:0] snpTag; logic [4:0] snpIdx; logic snpInv; logic snpDgr;
    logic eLdHit; logic [63:0] eLdData; logic eStHit; logic eFillRdy;
    logic eWbValid; logic chkWb; logic [7:0] eWbTag; logic [4:0] eWbIdx; logic [63:0] eWbData;
    logic eSnpHit; logic eSnpDirty; logic [63:0] eSnpData; logic eSnpWbHit;
  } vec_t;

  localparam logic [63:0] D10  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D11  = 64'h1100_0000_0000_0011;
  localparam logic [63:0] D12  = 64'h1200_0000_0000_0012;
  localparam logic [63:0] D13  = 64'h1300_0000_0000_0013;
  localparam logic [63:0] D14  = 64'h1400_0000_0000_0014;
  localparam logic [63:0] D14B = 64'h14B0_0000_0000_014B;
  localparam logic [63:0] D15  = 64'h1500_0000_0000_0015;
  localparam logic [63:0] D20  = 64'h2000_0000_0000_0020;
  localparam logic [63:0] D21  = 64'h2100_0000_0000_0021;
  localparam logic [63:0] D22  = 64'h2200_0000_0000_0022;
  localparam logic [63:0] D23  = 64'h2300_0000_0000_0023;
  localparam logic [63:0] D24  = 64'h2400_0000_0000_0024;
  localparam logic [63:0] D25  = 64'h2500_0000_0000_0025;
  localparam logic [63:0] STD  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] M10  = 64'h1111_2222_CCCC_DDDD;
  localparam logic [63:0] S21  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] M21  = 64'h5555_6666_0000_0021;

  vec_t        vecs[$];
  int          passCount = 0;
  int          totalCount = 0;
  logic        wbV = 1'b0;
  logic [7:0]  wbT = '0;
  logic [4:0]  wbI = '0;
  logic [63:0] wbD = '0;

  // Expected writeback-buffer contents as seen by the vectors built after this call.
  task automatic wbSet(input logic v, input logic [7:0] t, input logic [4:0] i, input logic [63:0] d);
    wbV = v; wbT = t; wbI = i; wbD = d;
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    v.eWbValid = wbV; v.eWbTag = wbT; v.eWbIdx = wbI; v.eWbData = wbD;
    return v;
  endfunction

  function automatic vec_t withLd(vec_t vi, logic [7:0] t, logic [4:0] i, logic hit, logic [63:0] d);
    vec_t v = vi;
    v.ldTag = t; v.ldIdx = i; v.eLdHit = hit; v.eLdData = d;
    return v;
  endfunction

  function automatic vec_t withSt(vec_t vi, logic [7:0] t, logic [4:0] i, logic [63:0] d,
                                  logic [7:0] be, logic hit);
    vec_t v = vi;
    v.stEn = 1'b1; v.stTag = t; v.stIdx = i; v.stData = d; v.stBe = be; v.eStHit = hit;
    return v;
  endfunction

  function automatic vec_t withFill(vec_t vi, logic [7:0] t, logic [4:0] i, logic [63:0] d, logic dty);
    vec_t v = vi;
    v.fillEn = 1'b1; v.fillTag = t; v.fillIdx = i; v.fillData = d; v.fillDirty = dty;
    return v;
  endfunction

  function automatic vec_t withSnp(vec_t vi, logic [7:0] t, logic [4:0] i, logic inv, logic dgr,
                                   logic hit, logic dty, logic [63:0] d, logic wbHit);
    vec_t v = vi;
    v.snpTag = t; v.snpIdx = i; v.snpInv = inv; v.snpDgr = dgr;
    v.eSnpHit = hit; v.eSnpDirty = dty; v.eSnpData = d; v.eSnpWbHit = wbHit;
    return v;
  endfunction

  function automatic vec_t prep(vec_t vi);
    vec_t v = vi;
    v.eFillRdy = !v.eWbValid || v.wbReady;
    v.chkWb    = v.chkWb || v.eWbValid;
    return v;
  endfunction

  task automatic push(input vec_t v);
    vecs.push_back(prep(v));
  endtask

  task automatic applyStimulus(input vec_t v);
    ld_tag_i = v.ldTag; ld_idx_i = v.ldIdx;
    st_en_i = v.stEn; st_tag_i = v.stTag; st_idx_i = v.stIdx; st_data_i = v.stData; st_be_i = v.stBe;
    fill_en_i = v.fillEn; fill_tag_i = v.fillTag; fill_idx_i = v.fillIdx;
    fill_data_i = v.fillData; fill_dirty_i = v.fillDirty;
    wb_ready_i = v.wbReady;
    snp_tag_i = v.snpTag; snp_idx_i = v.snpIdx; snp_inv_i = v.snpInv; snp_dgr_i = v.snpDgr;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else passCount++;
  endtask

  task automatic checkOutput(input vec_t v, input string n);
    check({n, ".ld_hit"},    64'(ld_hit_o),     64'(v.eLdHit));
    check({n, ".ld_data"},   ld_data_o,         v.eLdData);
    check({n, ".st_hit"},    64'(st_hit_o),     64'(v.eStHit));
    check({n, ".fill_rdy"},  64'(fill_rdy_o),   64'(v.eFillRdy));
    check({n, ".wb_valid"},  64'(wb_valid_o),   64'(v.eWbValid));
    check({n, ".snp_hit"},   64'(snp_hit_o),    64'(v.eSnpHit));
    check({n, ".snp_dirty"}, 64'(snp_dirty_o),  64'(v.eSnpDirty));
    check({n, ".snp_data"},  snp_data_o,        v.eSnpData);
    check({n, ".snp_wb_hit"}, 64'(snp_wb_hit_o), 64'(v.eSnpWbHit));
    if (v.chkWb) begin
      check({n, ".wb_tag"},  64'(wb_tag_o),  64'(v.eWbTag));
      check({n, ".wb_idx"},  64'(wb_idx_o),  64'(v.eWbIdx));
      check({n, ".wb_data"}, wb_data_o,      v.eWbData);
    end
  endtask

  task automatic runVec(input vec_t v, input string n);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v, n);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    applyStimulus('0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state, then fill idx 3 (0x11 dirty) and idx 5 (0x20 dirty) into empty ways.
    v = idle(); v.chkWb = 1'b1; push(v);
    push(withFill(idle(), 8'h10, 5'd3, D10, 1'b0));
    push(withFill(idle(), 8'h11, 5'd3, D11, 1'b1));
    push(withFill(idle(), 8'h12, 5'd3, D12, 1'b0));
    push(withFill(idle(), 8'h13, 5'd3, D13, 1'b0));
    push(withFill(idle(), 8'h20, 5'd5, D20, 1'b1));
    push(withFill(idle(), 8'h21, 5'd5, D21, 1'b0));
    push(withFill(idle(), 8'h22, 5'd5, D22, 1'b0));
    push(withFill(idle(), 8'h23, 5'd5, D23, 1'b0));
    push(withLd(idle(), 8'h12, 5'd3, 1'b1, D12));
    push(withLd(idle(), 8'h10, 5'd3, 1'b1, D10));
    // LRU is now way 1 (tag 0x11, dirty): it is evicted.
    push(withFill(idle(), 8'h14, 5'd3, D14, 1'b0));
    wbSet(1'b1, 8'h11, 5'd3, D11);
    push(withSnp(withLd(idle(), 8'h11, 5'd3, 1'b0, '0), 8'h11, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1));
    push(withFill(idle(), 8'h15, 5'd3, D15, 1'b0));
    push(withLd(idle(), 8'h15, 5'd3, 1'b0, '0));
    // Byte-masked store, then downgrade.
    push(withSnp(withSt(idle(), 8'h10, 5'd3, STD, 8'h0F, 1'b1), 8'h10, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, D10, 1'b0));
    push(withSnp(withLd(idle(), 8'h10, 5'd3, 1'b1, M10), 8'h10, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, M10, 1'b0));
    push(withSnp(withLd(idle(), 8'h10, 5'd3, 1'b1, M10), 8'h10, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, M10, 1'b0));
    // Dequeue and dirty-victim enqueue in the same cycle.
    v = withFill(idle(), 8'h24, 5'd5, D24, 1'b0); v.wbReady = 1'b1; push(v);
    wbSet(1'b1, 8'h20, 5'd5, D20);
    push(withSnp(idle(), 8'h20, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1));
    v = idle(); v.wbReady = 1'b1; push(v);
    wbSet(1'b0, '0, '0, '0);
    push(withSnp(idle(), 8'h12, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, D12, 1'b0));
    push(withLd(idle(), 8'h12, 5'd3, 1'b0, '0));
    // Fill and store hit the same way: fill wins, line stays clean.
    push(withSt(withFill(idle(), 8'h14, 5'd3, D14B, 1'b0), 8'h14, 5'd3, '1, 8'hFF, 1'b1));
    push(withSnp(withLd(idle(), 8'h14, 5'd3, 1'b1, D14B), 8'h14, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, D14B, 1'b0));

    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], $sformatf("V%0d", i));

    // Age a dirty way back to LRU through loads, evict it, then reset with the buffer full.
    runVec(prep(withSt(idle(), 8'h21, 5'd5, S21, 8'hF0, 1'b1)), "H1");
    runVec(prep(withLd(idle(), 8'h22, 5'd5, 1'b1, D22)), "H2");
    runVec(prep(withLd(idle(), 8'h23, 5'd5, 1'b1, D23)), "H3");
    runVec(prep(withLd(idle(), 8'h24, 5'd5, 1'b1, D24)), "H4");
    runVec(prep(withFill(idle(), 8'h25, 5'd5, D25, 1'b0)), "H5");
    wbSet(1'b1, 8'h21, 5'd5, M21);
    runVec(prep(idle()), "H6");

    @(negedge clk);
    rst = 1'b1;
    applyStimulus('0);
    @(negedge clk) rst = 1'b0;
    wbSet(1'b0, '0, '0, '0);
    v = withLd(idle(), 8'h10, 5'd3, 1'b0, '0); v.chkWb = 1'b1;
    runVec(prep(v), "R1");
    runVec(prep(withSnp(withLd(idle(), 8'h25, 5'd5, 1'b0, '0), 8'h21, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0)), "R2");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
